// File: rtl/lcd_spi_init_seq.sv
// ---------------------------------------------------------------------------
// lcd_spi_init_seq
// Power-up configurator for the LCD panel's 3-wire serial register port.
// Walks an external command ROM and sends 9-bit words (D/C bit first, then
// 8 data bits MSB first). It also executes millisecond delays and reports
// busy/done, so the system can hold the panel enable until configuration
// has finished.
//
// Parameters
//   CLK_DIV    clk_50 cycles per SCLK half-period
//   MS_CYCLES  clk_50 cycles per delay unit
//   ADDR_W     ROM address width (ROM depth = 2**ADDR_W)
//
// Ports
//   clk_50_i    system clock
//   reset_i     asynchronous, active-high reset
//   start_i     1-cycle pulse: run the sequence from address 0
//   rom_addr_o  command ROM address
//   rom_data_i  ROM word {kind[1:0], val[7:0]}; valid 1 cycle after the address
//   spi_cs_n_o  panel chip select, active low
//   spi_sclk_o  serial clock, idle low
//   spi_sdo_o   serial data; changes at the start of each low phase
//   busy_o      high while the sequence runs
//   done_o      high after the sequence ends; cleared by the next start
//
// ROM kind: 00 command byte, 01 data byte, 10 delay val*MS_CYCLES, 11 end.
//
// Optional build macro LCD_INIT_AUTOSTART_EN: a power-on counter waits
// 10*MS_CYCLES cycles after reset release and then starts the sequence once.
// The counter is not built when the macro is undefined.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | ROM read latency cycle
// DECODE | dispatch on the ROM kind field
// SHIFT  | cs_n low, 9 bits out on sclk/sdo
// GAP    | cs_n high for CLK_DIV cycles after a word
// DELAY  | count val*MS_CYCLES cycles
// NEXT   | advance the address or stop at the last ROM entry
// DONE   | sequence complete, waiting for a new start
// ---------------------------------------------------------------------------
module lcd_spi_init_seq #(
  parameter int CLK_DIV   = 25,
  parameter int MS_CYCLES = 50000,
  parameter int ADDR_W    = 5
) (
  input  logic              clk_50_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [9:0]        rom_data_i,
  output logic              spi_cs_n_o,
  output logic              spi_sclk_o,
  output logic              spi_sdo_o,
  output logic              busy_o,
  output logic              done_o
);

  // The delay counter holds up to 255*MS_CYCLES without overflow.
  localparam int DLY_W = 8 + $clog2(MS_CYCLES);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DLY_W-1:0] MS_L     = DLY_W'(MS_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SHIFT,
    S_GAP,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic               phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half
  logic [8:0]         shreg_q, shreg_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               go_start;

`ifdef LCD_INIT_AUTOSTART_EN
  localparam int POR_CYC = 10 * MS_CYCLES;
  localparam int POR_W   = $clog2(POR_CYC + 1);

  logic [POR_W-1:0] por_q;
  logic             armed_q;
  logic             auto_fire;

  // The single shot is spent when the counter expires even if the sequence
  // was already started by hand; it only fires from IDLE.
  assign auto_fire = armed_q && (por_q == '0) && (state_q == S_IDLE);
  assign go_start  = start_i | auto_fire;

  always_ff @(posedge clk_50_i or posedge reset_i) begin
    if (reset_i) begin
      por_q   <= POR_W'(POR_CYC - 1);
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (por_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        por_q <= por_q - POR_W'(1);
      end
    end
  end
`else
  assign go_start = start_i;
`endif

  // State and datapath registers
  always_ff @(posedge clk_50_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shreg_q <= '0;
      dly_q   <= '0;
      addr_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      dly_q   <= dly_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    dly_d   = dly_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        case (rom_data_i[9:8])
          2'b00, 2'b01: begin
            state_d = S_SHIFT;
            // D/C bit equals kind[0]
            shreg_d = {rom_data_i[8], rom_data_i[7:0]};
            div_d   = DIV_LOAD;
            phase_d = 1'b0;
            bit_d   = 4'd8;
          end
          2'b10: begin
            if (rom_data_i[7:0] == 8'd0) begin
              state_d = S_NEXT;
            end else begin
              state_d = S_DELAY;
              dly_d   = DLY_W'(rom_data_i[7:0]) * MS_L - DLY_W'(1);
            end
          end
          default: state_d = S_DONE;
        endcase
      end

      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (!phase_q) begin
          phase_d = 1'b1;
          div_d   = DIV_LOAD;
        end else if (bit_q == 4'd0) begin
          state_d = S_GAP;
          phase_d = 1'b0;
          div_d   = DIV_LOAD;
        end else begin
          phase_d = 1'b0;
          div_d   = DIV_LOAD;
          bit_d   = bit_q - 4'd1;
          shreg_d = {shreg_q[7:0], 1'b0};
        end
      end

      S_GAP: begin
        if (div_q == '0) begin
          state_d = S_NEXT;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      S_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_NEXT;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end

      S_NEXT: begin
        // Stop at the last ROM entry instead of wrapping to address 0.
        if (addr_q == '1) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered pins line up
  // with the state they belong to (cs_n low in the first SHIFT cycle).
  always_comb begin
    cs_n_d = (state_d != S_SHIFT);
    sclk_d = (state_d == S_SHIFT) && phase_d;
    sdo_d  = (state_d == S_SHIFT) ? shreg_d[8] : sdo_q;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign rom_addr_o = addr_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_sclk_o = sclk_q;
  assign spi_sdo_o  = sdo_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
